// File: rtl/rtc_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// rtc_access_sequencer_if
// Request/acknowledge register bus between the RTC access sequencer and the
// RTC interface driver.
//
//   rtc_req   : transfer request, held until rtc_ack
//   rtc_wr    : 1 = write, 0 = read
//   rtc_addr  : RTC register address
//   rtc_wdata : write data
//   rtc_ack   : transfer complete (one cycle)
//   rtc_rdata : read data, valid while rtc_ack = 1
//
// master = sequencer side, slave = RTC driver side.
// -----------------------------------------------------------------------------
interface rtc_access_sequencer_if;
   logic       rtc_req;
   logic       rtc_wr;
   logic [7:0] rtc_addr;
   logic [7:0] rtc_wdata;
   logic       rtc_ack;
   logic [7:0] rtc_rdata;

   modport master (
      output rtc_req, rtc_wr, rtc_addr, rtc_wdata,
      input  rtc_ack, rtc_rdata
   );

   modport slave (
      input  rtc_req, rtc_wr, rtc_addr, rtc_wdata,
      output rtc_ack, rtc_rdata
   );
endinterface

// File: rtl/rtc_access_sequencer.sv
// -----------------------------------------------------------------------------
// rtc_access_sequencer
// Sequences all register traffic between the clock/date/timer configuration
// counters and the RTC interface driver.
//   - Holds the configuration mode written by the PicoBlaze (port 8'h12) and
//     drives it to the configuration counters.
//   - A commit (port 8'h13 bit 0) writes the three counter values selected by
//     the mode to the RTC as a three-byte burst.
//   - read_tick requests a six-byte read burst of the time/date registers.
//   - Commit and read bursts share one req/ack bus; commit wins when both
//     are pending.
//
// Ports:
//   clk, reset           : system clock, asynchronous active-high reset
//   port_id, in_dato     : PicoBlaze port address / output data
//   write_strobe,
//   k_write_strobe       : PicoBlaze write strobes (either one writes)
//   btn_data_*           : live counter values (time, date, timer)
//   read_tick            : one-cycle request for a read burst
//   config_mode          : current mode (0 normal, 1 time, 2 date, 4 timer)
//   rtc                  : req/ack bus to the RTC driver (master side)
//   rd_valid/addr/data   : one pulse per byte returned by a read burst
//   busy                 : a burst is in progress
//   done                 : one-cycle pulse when a commit burst completes
//   err                  : sticky ack timeout flag, cleared by port 8'h13 bit 7
// -----------------------------------------------------------------------------
module rtc_access_sequencer #(
   parameter int TIMEOUT_CYC = 1023,
   parameter int TW          = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] in_dato,
   input  logic       write_strobe,
   input  logic       k_write_strobe,
   input  logic [7:0] btn_data_SS,
   input  logic [7:0] btn_data_MM,
   input  logic [7:0] btn_data_HH,
   input  logic [7:0] btn_data_YEAR,
   input  logic [7:0] btn_data_MES,
   input  logic [7:0] btn_data_DAY,
   input  logic [7:0] btn_data_SS_T,
   input  logic [7:0] btn_data_MM_T,
   input  logic [7:0] btn_data_HH_T,
   input  logic       read_tick,
   output logic [2:0] config_mode,
   rtc_access_sequencer_if.master rtc,
   output logic       rd_valid,
   output logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GAP
   } state_t;

   localparam logic [7:0] PORT_MODE = 8'h12;
   localparam logic [7:0] PORT_CTRL = 8'h13;
   localparam logic [7:0] RD_BASE   = 8'h21;
   localparam logic [2:0] WR_LAST   = 3'd2;
   localparam logic [2:0] RD_LAST   = 3'd5;

   state_t        state;
   logic [2:0]    idx;
   logic [2:0]    burst_mode;   // mode captured at commit start, drives the address map
   logic [TW-1:0] tcnt;
   logic          commit_pend;
   logic          read_pend;
   logic [7:0]    snap [3];     // counter values frozen for the running commit
   logic [7:0]    live [3];     // counter values selected by the current mode

   logic          strobe;
   logic          mode_wr;
   logic          ctrl_wr;
   logic          mode_ok;
   logic [2:0]    nxt_idx;
   logic          last_idx;
   logic          timeout_hit;
   logic          unused_ok;

   assign strobe      = write_strobe | k_write_strobe;
   assign mode_wr     = strobe && (port_id == PORT_MODE);
   assign ctrl_wr     = strobe && (port_id == PORT_CTRL);
   assign mode_ok     = in_dato[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4};
   assign nxt_idx     = idx + 3'd1;
   assign last_idx    = rtc.rtc_wr ? (idx == WR_LAST) : (idx == RD_LAST);
   // Comparing against TIMEOUT_CYC-1 keeps rtc_req high for exactly
   // TIMEOUT_CYC cycles when no ack arrives.
   assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 1));
   assign unused_ok   = &{1'b0, in_dato[6:3]};

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      live[0] = btn_data_SS;
      live[1] = btn_data_MM;
      live[2] = btn_data_HH;
      case (config_mode)
         3'd2: begin
            live[0] = btn_data_DAY;
            live[1] = btn_data_MES;
            live[2] = btn_data_YEAR;
         end
         3'd4: begin
            live[0] = btn_data_SS_T;
            live[1] = btn_data_MM_T;
            live[2] = btn_data_HH_T;
         end
         default: ;
      endcase
   end

   // First RTC register of the three-byte write group for a mode.
   function automatic logic [7:0] wr_base(input logic [2:0] mode);
      case (mode)
         3'd2:    wr_base = 8'h24;
         3'd4:    wr_base = 8'h41;
         default: wr_base = 8'h21;
      endcase
   endfunction

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order;
   // later assignments in this block deliberately override earlier ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         burst_mode    <= '0;
         tcnt          <= '0;
         commit_pend   <= 1'b0;
         read_pend     <= 1'b0;
         config_mode   <= '0;
         rtc.rtc_req   <= 1'b0;
         rtc.rtc_wr    <= 1'b0;
         rtc.rtc_addr  <= '0;
         rtc.rtc_wdata <= '0;
         rd_valid      <= 1'b0;
         rd_addr       <= '0;
         rd_data       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         // NOTE: the snapshot is only three bytes and feeds rtc_wdata, so it
         // is reset rather than left unknown like a RAM would be.
         for (int i = 0; i < 3; i++) snap[i] <= '0;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;

         if (mode_wr && state == IDLE && mode_ok) config_mode <= in_dato[2:0];
         if (ctrl_wr && in_dato[7])               err         <= 1'b0;

         case (state)
            IDLE: begin
               if (commit_pend) begin
                  commit_pend <= 1'b0;
                  // A mode-0 commit cannot normally be pending; drop it quietly.
                  if (config_mode != 3'd0) begin
                     snap          <= live;
                     burst_mode    <= config_mode;
                     idx           <= '0;
                     rtc.rtc_wr    <= 1'b1;
                     rtc.rtc_addr  <= wr_base(config_mode);
                     rtc.rtc_wdata <= live[0];
                     rtc.rtc_req   <= 1'b1;
                     busy          <= 1'b1;
                     state         <= REQ;
                  end
               end else if (read_pend) begin
                  read_pend     <= 1'b0;
                  idx           <= '0;
                  rtc.rtc_wr    <= 1'b0;
                  rtc.rtc_addr  <= RD_BASE;
                  rtc.rtc_wdata <= '0;
                  rtc.rtc_req   <= 1'b1;
                  busy          <= 1'b1;
                  state         <= REQ;
               end
            end

            REQ: begin
               if (rtc.rtc_ack) begin
                  rtc.rtc_req <= 1'b0;
                  state       <= GAP;
                  if (!rtc.rtc_wr) begin
                     rd_valid <= 1'b1;
                     rd_addr  <= rtc.rtc_addr;
                     rd_data  <= rtc.rtc_rdata;
                  end
               end else if (timeout_hit) begin
                  // Abandon the rest of the burst; mode stays for a retry.
                  err         <= 1'b1;
                  rtc.rtc_req <= 1'b0;
                  tcnt        <= '0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            GAP: begin
               tcnt <= '0;
               if (last_idx) begin
                  busy  <= 1'b0;
                  state <= IDLE;
                  if (rtc.rtc_wr) begin
                     done        <= 1'b1;
                     config_mode <= '0;
                  end
               end else begin
                  idx         <= nxt_idx;
                  rtc.rtc_req <= 1'b1;
                  state       <= REQ;
                  if (rtc.rtc_wr) begin
                     rtc.rtc_addr  <= wr_base(burst_mode) + {5'd0, nxt_idx};
                     rtc.rtc_wdata <= snap[nxt_idx[1:0]];
                  end else begin
                     rtc.rtc_addr  <= RD_BASE + {5'd0, nxt_idx};
                  end
               end
            end

            default: begin
               rtc.rtc_req <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase

         // New requests win over the consume in IDLE so none is lost.
         if (ctrl_wr && in_dato[0] && config_mode != 3'd0) commit_pend <= 1'b1;
         if (read_tick)                                    read_pend   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rtc_access_sequencer
// Self-checking bench for rtc_access_sequencer: an RTC responder on the
// req/ack bus logs every acknowledged transfer, and expected transfer lists
// are built from the mode/address tables and the counter values.
// -----------------------------------------------------------------------------
module tb_rtc_access_sequencer;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_id, in_dato;
   logic       write_strobe, k_write_strobe, read_tick;
   logic [7:0] ss, mm, hh, yr, mes, day, ss_t, mm_t, hh_t;
   logic [2:0] config_mode;
   logic       rd_valid;
   logic [7:0] rd_addr, rd_data;
   logic       busy, done, err;

   rtc_access_sequencer_if rtc ();

   rtc_access_sequencer #(.TIMEOUT_CYC(1023), .TW(10)) dut (
      .clk            (clk),
      .reset          (reset),
      .port_id        (port_id),
      .in_dato        (in_dato),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .btn_data_SS    (ss),
      .btn_data_MM    (mm),
      .btn_data_HH    (hh),
      .btn_data_YEAR  (yr),
      .btn_data_MES   (mes),
      .btn_data_DAY   (day),
      .btn_data_SS_T  (ss_t),
      .btn_data_MM_T  (mm_t),
      .btn_data_HH_T  (hh_t),
      .read_tick      (read_tick),
      .config_mode    (config_mode),
      .rtc            (rtc.master),
      .rd_valid       (rd_valid),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   txn_t obs_q[$], exp_q[$], rd_obs_q[$], rd_exp_q[$];
   int   gap_q[$];
   int   done_cnt = 0;
   int   low_run = 0, hi_run = 0, last_hi_run = 0;
   int   wait_cnt = 0;
   int   ack_dly_max = 0;
   bit   ack_off = 1'b0;
   bit   rd_plus1 = 1'b1;

   // RTC responder: acks each request after 0..ack_dly_max idle cycles.
   always @(negedge clk) begin
      if (reset) begin
         rtc.rtc_ack = 1'b0;
         wait_cnt    = 0;
      end else if (rtc.rtc_ack) begin
         rtc.rtc_ack = 1'b0;
      end else if (rtc.rtc_req && !ack_off) begin
         if (wait_cnt == 0) begin
            rtc.rtc_rdata = rd_plus1 ? rtc.rtc_addr + 8'd1 : 8'($urandom);
            rtc.rtc_ack   = 1'b1;
            obs_q.push_back('{rtc.rtc_wr, rtc.rtc_addr, rtc.rtc_wdata});
            if (!rtc.rtc_wr) rd_exp_q.push_back('{1'b0, rtc.rtc_addr, rtc.rtc_rdata});
            wait_cnt = $urandom_range(ack_dly_max, 0);
         end else begin
            wait_cnt--;
         end
      end
   end

   // Output monitor: done pulses, returned bytes, req high/low run lengths.
   always @(negedge clk) begin
      if (reset) begin
         low_run = 0;
         hi_run  = 0;
      end else begin
         if (done) done_cnt++;
         if (rd_valid) rd_obs_q.push_back('{1'b0, rd_addr, rd_data});
         if (rtc.rtc_req) begin
            if (hi_run == 0) gap_q.push_back(low_run);
            hi_run++;
            low_run = 0;
         end else begin
            if (hi_run != 0) last_hi_run = hi_run;
            hi_run = 0;
            low_run++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pb_write(input logic [7:0] port, input logic [7:0] data, input bit tick);
      @(negedge clk);
      port_id = port;
      in_dato = data;
      if ($urandom_range(1, 0) == 1) write_strobe = 1'b1;
      else                           k_write_strobe = 1'b1;
      read_tick = tick;
      @(negedge clk);
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
      read_tick      = 1'b0;
      port_id        = 8'h00;
      in_dato        = 8'h00;
   endtask

   task automatic pulse_read();
      @(negedge clk);
      read_tick = 1'b1;
      @(negedge clk);
      read_tick = 1'b0;
   endtask

   task automatic clear_logs();
      obs_q.delete();
      exp_q.delete();
      rd_obs_q.delete();
      rd_exp_q.delete();
      gap_q.delete();
      done_cnt    = 0;
      last_hi_run = 0;
   endtask

   task automatic wait_bursts(input int n_txn, input int budget, input string tag);
      int n = 0;
      while (!(obs_q.size() >= n_txn && !busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_in_time"}, 32'(n < budget), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic randomize_values();
      ss = 8'($urandom);   mm = 8'($urandom);   hh = 8'($urandom);
      yr = 8'($urandom);   mes = 8'($urandom);  day = 8'($urandom);
      ss_t = 8'($urandom); mm_t = 8'($urandom); hh_t = 8'($urandom);
   endtask

   // Reference: commit writes the mode's three counters to its register group.
   task automatic model_commit(input logic [2:0] mode);
      logic [7:0] a [3];
      logic [7:0] v [3];
      case (mode)
         3'd1:    begin a = '{8'h21, 8'h22, 8'h23}; v = '{ss, mm, hh};       end
         3'd2:    begin a = '{8'h24, 8'h25, 8'h26}; v = '{day, mes, yr};     end
         default: begin a = '{8'h41, 8'h42, 8'h43}; v = '{ss_t, mm_t, hh_t}; end
      endcase
      for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, a[i], v[i]});
   endtask

   // Reference: a read burst visits registers 8'h21..8'h26 in order.
   task automatic model_read();
      for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, 8'(8'h21 + i), 8'h00});
   endtask

   task automatic compare_txns(input string tag);
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i].wr), 32'(exp_q[i].wr));
         check($sformatf("%s_addr%0d", tag, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
         if (exp_q[i].wr)
            check($sformatf("%s_wdata%0d", tag, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      end
   endtask

   task automatic compare_reads(input string tag);
      check({tag, "_rd_count"}, 32'(rd_obs_q.size()), 32'(rd_exp_q.size()));
      for (int i = 0; i < rd_obs_q.size() && i < rd_exp_q.size(); i++) begin
         check($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_obs_q[i].addr), 32'(rd_exp_q[i].addr));
         check($sformatf("%s_rd_data%0d", tag, i), 32'(rd_obs_q[i].data), 32'(rd_exp_q[i].data));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int         n, lows;
   bit         seen;
   int         modes [3] = '{1, 2, 4};
   logic [2:0] mode_v;
   bit         tick_v;

   initial begin
      reset = 1'b1;
      port_id = 8'h00; in_dato = 8'h00;
      write_strobe = 1'b0; k_write_strobe = 1'b0; read_tick = 1'b0;
      rtc.rtc_ack = 1'b0; rtc.rtc_rdata = 8'h00;
      randomize_values();
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_mode", 32'(config_mode), 32'd0);
      check("rst_req", 32'(rtc.rtc_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_addr", 32'(rtc.rtc_addr), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Time commit with single-cycle acks.
      ss = 8'h30; mm = 8'h15; hh = 8'h09;
      pb_write(8'h12, 8'h01, 1'b0);
      check("t1_mode_set", 32'(config_mode), 32'd1);
      clear_logs();
      pb_write(8'h13, 8'h01, 1'b0);
      wait_bursts(3, 100, "t1");
      model_commit(3'd1);
      compare_txns("t1");
      check("t1_gaps", 32'(gap_q.size()), 32'd3);
      if (gap_q.size() == 3) begin
         check("t1_gap1", 32'(gap_q[1]), 32'd1);
         check("t1_gap2", 32'(gap_q[2]), 32'd1);
      end
      check("t1_done", 32'(done_cnt), 32'd1);
      check("t1_mode_back", 32'(config_mode), 32'd0);

      // Read burst, rdata = addr + 1.
      clear_logs();
      pulse_read();
      wait_bursts(6, 100, "t2");
      model_read();
      compare_txns("t2");
      check("t2_rd_count", 32'(rd_obs_q.size()), 32'd6);
      for (int i = 0; i < rd_obs_q.size(); i++) begin
         check($sformatf("t2_rd_addr%0d", i), 32'(rd_obs_q[i].addr), 32'(8'h21 + i));
         check($sformatf("t2_rd_data%0d", i), 32'(rd_obs_q[i].data), 32'(8'h22 + i));
      end
      check("t2_done", 32'(done_cnt), 32'd0);

      // Commit (date) and read_tick in the same cycle.
      randomize_values();
      pb_write(8'h12, 8'h02, 1'b0);
      clear_logs();
      pb_write(8'h13, 8'h01, 1'b1);
      n = 0; lows = 0; seen = 1'b0;
      while (!(obs_q.size() >= 9 && !busy) && n < 300) begin
         @(negedge clk);
         n++;
         if (busy) seen = 1'b1;
         else if (seen && obs_q.size() < 9) lows++;
      end
      check("t3_in_time", 32'(n < 300), 32'd1);
      check("t3_idle_cycles", 32'(lows), 32'd1);
      repeat (3) @(negedge clk);
      model_commit(3'd2);
      model_read();
      compare_txns("t3");
      compare_reads("t3");
      check("t3_done", 32'(done_cnt), 32'd1);

      // Randomized commits, values, ack latencies and optional reads.
      rd_plus1 = 1'b0;
      ack_dly_max = 3;
      for (int it = 0; it < 6; it++) begin
         mode_v = 3'(modes[$urandom_range(2, 0)]);
         tick_v = 1'($urandom_range(1, 0));
         randomize_values();
         pb_write(8'h12, {5'd0, mode_v}, 1'b0);
         clear_logs();
         pb_write(8'h13, 8'h01, tick_v);
         wait_bursts(tick_v ? 9 : 3, 400, $sformatf("r%0d", it));
         model_commit(mode_v);
         if (tick_v) model_read();
         compare_txns($sformatf("r%0d", it));
         compare_reads($sformatf("r%0d", it));
         check($sformatf("r%0d_done", it), 32'(done_cnt), 32'd1);
         check($sformatf("r%0d_mode", it), 32'(config_mode), 32'd0);
      end
      ack_dly_max = 0;
      rd_plus1 = 1'b1;

      // Timeout: no ack at all.
      pb_write(8'h12, 8'h01, 1'b0);
      clear_logs();
      ack_off = 1'b1;
      pb_write(8'h13, 8'h01, 1'b0);
      n = 0; seen = 1'b0;
      while (!(seen && !busy) && n < 1200) begin
         @(negedge clk);
         n++;
         if (busy) seen = 1'b1;
      end
      check("to_in_time", 32'(n < 1200), 32'd1);
      repeat (2) @(negedge clk);
      ack_off = 1'b0;
      check("to_req_cycles", 32'(last_hi_run), 32'd1023);
      check("to_err", 32'(err), 32'd1);
      check("to_done", 32'(done_cnt), 32'd0);
      check("to_mode", 32'(config_mode), 32'd1);
      check("to_no_txn", 32'(obs_q.size()), 32'd0);
      pb_write(8'h13, 8'h80, 1'b0);
      check("to_err_clear", 32'(err), 32'd0);
      check("to_mode_kept", 32'(config_mode), 32'd1);

      // Mode filtering.
      pb_write(8'h12, 8'h03, 1'b0);
      check("flt_mode3", 32'(config_mode), 32'd1);
      clear_logs();
      pulse_read();
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("flt_busy_seen", 32'(busy), 32'd1);
      pb_write(8'h12, 8'h04, 1'b0);
      check("flt_mode_busy", 32'(config_mode), 32'd1);
      wait_bursts(6, 100, "flt");
      check("flt_mode_after", 32'(config_mode), 32'd1);
      pb_write(8'h12, 8'h00, 1'b0);
      check("flt_mode0", 32'(config_mode), 32'd0);
      clear_logs();
      pb_write(8'h13, 8'h01, 1'b0);
      repeat (20) @(negedge clk);
      check("flt_no_bus", 32'(obs_q.size()) + 32'(gap_q.size()), 32'd0);
      check("flt_no_done", 32'(done_cnt), 32'd0);

      // Asynchronous reset during the second byte of a commit.
      randomize_values();
      pb_write(8'h12, 8'h01, 1'b0);
      clear_logs();
      pb_write(8'h13, 8'h01, 1'b0);
      n = 0;
      while (obs_q.size() < 1 && n < 50) begin @(negedge clk); n++; end
      while (rtc.rtc_req && n < 50) begin @(negedge clk); n++; end
      while (!rtc.rtc_req && n < 50) begin @(negedge clk); n++; end
      check("ar_second_req", 32'(rtc.rtc_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("ar_req", 32'(rtc.rtc_req), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_mode", 32'(config_mode), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("ar_no_done", 32'(done_cnt), 32'd0);
      clear_logs();
      pulse_read();
      wait_bursts(6, 100, "ar");
      check("ar_first_addr", (obs_q.size() > 0) ? 32'(obs_q[0].addr) : 32'hffff_ffff, 32'h21);
      model_read();
      compare_txns("ar");
      compare_reads("ar");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
